// File: rtl/mpc_mul_arb_pkg.sv
// Shared widths and helpers for the multiplier-sharing arbiter.
// Operand/product widths match a signed 21x9 multiplier with a 30-bit product.
package mpc_mul_arb_pkg;

    localparam int A_W     = 21;
    localparam int B_W     = 9;
    localparam int P_W     = 30;
    localparam int DEF_LAT = 4;

    // Ceiling log2, used to size requester ids (NUM_REQ >= 2 gives at least 1 bit).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mpc_rr_arbiter.sv
// Round-robin priority select: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus its index; nothing is granted when en is low.
module mpc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && !any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mpc_mul_arbiter.sv
// Shares one external LAT-deep signed 21x9 multiplier among NUM_REQ requesters.
// Define MPC_MUL_ARB_PERF_EN to add perf_issue_cnt / perf_stall_cnt outputs.
module mpc_mul_arbiter
    import mpc_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = DEF_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_a,
    output logic [B_W-1:0]         mul_b,
    input  logic [P_W-1:0]         mul_p,
    output logic                   busy
`ifdef MPC_MUL_ARB_PERF_EN
    ,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int IW = clog2(NUM_REQ);

    // Handshakes: a request transfers on req_valid & req_ready; a result retires on
    // rsp_valid & rsp_ready and holds stable (with the whole pipe frozen) until then.

    logic [LAT-1:0] slot_v;
    logic [IW-1:0]  slot_id [LAT];
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_nxt;

    logic           out_v;
    logic [IW-1:0]  out_id;
    logic           stall;
    logic           grant_en;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;

    assign out_v  = slot_v[LAT-1];
    assign out_id = slot_id[LAT-1];
    assign stall  = out_v & ~rsp_ready[out_id];

    // In reset the multiplier is kept running so stale contents flush behind cleared valids.
    assign mul_ce   = ~stall | ~reset;
    assign grant_en = reset & ~stall;

    mpc_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .en  (grant_en),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = gnt;
    assign ptr_nxt   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign busy      = reset & (|slot_v);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mul_a = req_a[i*A_W +: A_W];
                mul_b = req_b[i*B_W +: B_W];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_p     = '0;
        if (reset && out_v) begin
            rsp_valid[out_id] = 1'b1;
            rsp_p             = mul_p;
        end
    end

    // Tracking pipe mirrors the multiplier stage-for-stage; ids need no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_v <= '0;
            ptr    <= '0;
        end else if (!stall) begin
            slot_v[0]  <= gnt_any;
            slot_id[0] <= gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                slot_v[i]  <= slot_v[i-1];
                slot_id[i] <= slot_id[i-1];
            end
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
        end
    end

`ifdef MPC_MUL_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (gnt_any) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
